encoder_homing_sequencer: RTL and testbench

- Sequences the homing run of a DC-motor axis from the quadrature-encoder outputs.
- Inputs used: the encoder's signed 32-bit counter and its cw/ccw step pulses, plus a home limit switch.
- Drives the motor toward home, brakes, zeroes the encoder through its reset input, then backs off a fixed count.
- Monitors the run for stall and abort, and reports done/error to the host logic.

---
 rtl/encoder_homing_sequencer.sv | 121 ++++++++++++
 tb/tb_encoder_homing_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/encoder_homing_sequencer.sv
// encoder_homing_sequencer: homes a DC-motor axis from its quadrature encoder and home switch.
// Seeks ccw to the switch, settles, zeroes the encoder, backs off cw, and watches for stall/abort.
module encoder_homing_sequencer #(
    parameter int CNT_W          = 32,
    parameter int STALL_TIMEOUT  = 50000,
    parameter int SETTLE_CYCLES  = 1000,
    parameter int BACKOFF_COUNTS = 200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             home_sw,
    input  logic [CNT_W-1:0] enc_counter,
    input  logic             enc_cw,
    input  logic             enc_ccw,
    output logic             motor_en,
    output logic             motor_dir,
    output logic             enc_reset,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code
);
    localparam int TW = $clog2(STALL_TIMEOUT);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, SEEK, BRAKE, ZERO, WAITZ, BACKOFF, FINISH, ERROR} state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_q, sync_d, err_code_q, err_code_d;
    logic [TW-1:0] stall_q, stall_d;
    logic [SW-1:0] settle_q, settle_d;
    logic          motor_en_q, motor_en_d, motor_dir_q, motor_dir_d, enc_reset_q, enc_reset_d;
    logic          busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic          home_s, pulse, stall, go, active, run;

    always_comb begin
        sync_d     = {sync_q[0], home_sw};
        home_s     = sync_q[1];
        pulse      = enc_cw | enc_ccw;
        stall      = stall_q == TW'(STALL_TIMEOUT - 1) && !pulse;
        go         = start && !abort;
        active     = state_q != IDLE && state_q != ERROR;
        state_d    = state_q;
        err_code_d = err_code_q;
        if (active && abort) begin
            state_d    = ERROR;
            err_code_d = 2'b11;
        end else begin
            case (state_q)
                IDLE, ERROR: if (go) begin
                    state_d    = home_s ? BRAKE : SEEK;
                    err_code_d = 2'b00;
                end
                SEEK: if (home_s) state_d = BRAKE;
                    else if (stall) begin
                        state_d    = ERROR;
                        err_code_d = 2'b01;
                    end
                BRAKE: if (settle_q == SW'(SETTLE_CYCLES - 1)) state_d = ZERO;
                ZERO: state_d = WAITZ;
                WAITZ: if (enc_counter == '0) state_d = BACKOFF;
                BACKOFF: if ($signed(enc_counter) >= $signed(CNT_W'(BACKOFF_COUNTS))) state_d = FINISH;
                    else if (stall) begin
                        state_d    = ERROR;
                        err_code_d = 2'b10;
                    end
                FINISH: state_d = IDLE;
            endcase
        end
        run         = state_d == SEEK || state_d == BACKOFF;
        // Timer restarts on every entry into a driving state and on any encoder step.
        stall_d     = (!run || state_d != state_q || pulse) ? '0 :
                      (stall_q == TW'(STALL_TIMEOUT - 1)) ? stall_q : stall_q + 1'b1;
        settle_d    = (state_q == BRAKE && state_d == BRAKE) ? settle_q + 1'b1 : '0;
        motor_en_d  = run;
        motor_dir_d = state_d == SEEK;
        // Pulses fire on leaving ZERO/FINISH normally, so an abort there suppresses them.
        enc_reset_d = state_q == ZERO && state_d == WAITZ;
        done_d      = state_q == FINISH && state_d == IDLE;
        busy_d      = state_d != IDLE && state_d != ERROR;
        error_d     = state_d == ERROR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sync_q      <= '0;
            err_code_q  <= '0;
            stall_q     <= '0;
            settle_q    <= '0;
            motor_en_q  <= 1'b0;
            motor_dir_q <= 1'b0;
            enc_reset_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            err_code_q  <= err_code_d;
            stall_q     <= stall_d;
            settle_q    <= settle_d;
            motor_en_q  <= motor_en_d;
            motor_dir_q <= motor_dir_d;
            enc_reset_q <= enc_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign motor_en  = motor_en_q;
    assign motor_dir = motor_dir_q;
    assign enc_reset = enc_reset_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_code  = err_code_q;
endmodule

// File: tb/tb_encoder_homing_sequencer.sv
// tb_encoder_homing_sequencer: directed checks of the homing sequencer with a behavioural encoder.
module tb_encoder_homing_sequencer;
    logic        clk = 1'b0;
    logic        reset, start, abort, home_sw, enc_cw, enc_ccw;
    logic signed [31:0] cnt = 0;
    logic        motor_en, motor_dir, enc_reset, busy, done, error;
    logic [1:0]  err_code;
    int          n_chk = 0, n_pass = 0, n_rst = 0, n_done = 0;

    encoder_homing_sequencer #(
        .CNT_W(32), .STALL_TIMEOUT(20), .SETTLE_CYCLES(5), .BACKOFF_COUNTS(4)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .home_sw(home_sw),
        .enc_counter(cnt), .enc_cw(enc_cw), .enc_ccw(enc_ccw),
        .motor_en(motor_en), .motor_dir(motor_dir), .enc_reset(enc_reset),
        .busy(busy), .done(done), .error(error), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Encoder: counts steps, zeroed one edge after its reset input is seen high.
    always @(posedge clk) cnt <= enc_reset ? 0 : cnt + (enc_cw ? 1 : 0) - (enc_ccw ? 1 : 0);

    always @(negedge clk) begin
        if (enc_reset) n_rst++;
        if (done) n_done++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic backoff_to_done();
        for (int i = 0; i < 4; i++) begin
            enc_cw = 1'b1; tick(1); enc_cw = 1'b0; tick(2);
        end
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_motor", motor_en, 0);
    endtask

    task automatic run_nominal();
        int r0, d0;
        r0 = n_rst; d0 = n_done;
        start = 1'b1; tick(1); start = 1'b0;
        chk("seek_en", motor_en, 1);
        chk("seek_dir", motor_dir, 1);
        chk("seek_busy", busy, 1);
        for (int i = 0; i < 10; i++) begin
            enc_ccw = 1'b1; tick(1); enc_ccw = 1'b0; tick(3);
        end
        chk("seek_hold", motor_en, 1);
        home_sw = 1'b1; tick(2);
        chk("home_2cyc_en", motor_en, 1);
        tick(1);
        chk("home_3cyc_en", motor_en, 0);
        chk("brake_busy", busy, 1);
        tick(5);
        chk("settle_no_rst", enc_reset, 0);
        tick(1);
        chk("zero_rst", enc_reset, 1);
        tick(2);
        chk("backoff_en", motor_en, 1);
        chk("backoff_dir", motor_dir, 0);
        backoff_to_done();
        tick(1);
        chk("done_one_cycle", done, 0);
        chk("one_rst", n_rst - r0, 1);
        chk("one_done", n_done - d0, 1);
    endtask

    initial begin
        int r0, d0;
        reset = 1'b1; start = 1'b0; abort = 1'b0; home_sw = 1'b0; enc_cw = 1'b0; enc_ccw = 1'b0;
        tick(2);
        chk("rst_motor", motor_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_error", error, 0);
        chk("rst_code", err_code, 0);
        reset = 1'b0; tick(1);

        run_nominal();

        // Start with the switch already closed: straight to BRAKE.
        start = 1'b1; tick(1); start = 1'b0;
        chk("sw_brake_en", motor_en, 0);
        chk("sw_brake_busy", busy, 1);
        tick(5);
        chk("sw_no_rst", enc_reset, 0);
        tick(1);
        chk("sw_rst", enc_reset, 1);
        tick(2);
        backoff_to_done();

        // Stall in SEEK.
        home_sw = 1'b0; tick(3);
        start = 1'b1; tick(1); start = 1'b0;
        chk("stall_seek_en", motor_en, 1);
        tick(19);
        chk("stall_pre_err", error, 0);
        tick(1);
        chk("stall_err", error, 1);
        chk("stall_code", err_code, 1);
        chk("stall_motor", motor_en, 0);
        chk("stall_busy", busy, 0);
        start = 1'b1; tick(1); start = 1'b0;
        chk("restart_code", err_code, 0);
        chk("restart_err", error, 0);
        chk("restart_seek", motor_dir, 1);

        // Home again, then stall in BACKOFF after two pulses spaced 19 cycles.
        home_sw = 1'b1; tick(3);
        tick(6);
        chk("rs_rst", enc_reset, 1);
        tick(2);
        chk("bo_en", motor_en, 1);
        enc_cw = 1'b1; tick(1); enc_cw = 1'b0; tick(18);
        enc_cw = 1'b1; tick(1); enc_cw = 1'b0;
        chk("bo_no_stall", error, 0);
        chk("bo_cnt2", cnt, 2);
        tick(19);
        chk("bo_pre_err", error, 0);
        tick(1);
        chk("bo_err", error, 1);
        chk("bo_code", err_code, 2);
        chk("bo_motor", motor_en, 0);

        // Abort mid-BRAKE, then start while abort is held.
        start = 1'b1; tick(1); start = 1'b0;
        chk("ab_clear", err_code, 0);
        chk("ab_brake", busy, 1);
        r0 = n_rst; d0 = n_done;
        tick(2);
        abort = 1'b1; tick(1); abort = 1'b0;
        chk("ab_err", error, 1);
        chk("ab_code", err_code, 3);
        chk("ab_busy", busy, 0);
        tick(8);
        chk("ab_no_rst", n_rst - r0, 0);
        chk("ab_no_done", n_done - d0, 0);
        abort = 1'b1; start = 1'b1; tick(2);
        chk("ab_start_ign", err_code, 3);
        chk("ab_start_busy", busy, 0);
        start = 1'b0; abort = 1'b0; tick(1);

        // Synchronous reset during BACKOFF.
        start = 1'b1; tick(1); start = 1'b0;
        tick(6);
        chk("rb_rst", enc_reset, 1);
        tick(2);
        chk("rb_backoff", motor_en, 1);
        d0 = n_done;
        enc_cw = 1'b1; tick(1); enc_cw = 1'b0;
        reset = 1'b1; tick(1);
        chk("rb_motor", motor_en, 0);
        chk("rb_busy", busy, 0);
        chk("rb_error", error, 0);
        chk("rb_code", err_code, 0);
        chk("rb_encrst", enc_reset, 0);
        chk("rb_dir", motor_dir, 0);
        reset = 1'b0; home_sw = 1'b0; tick(3);
        chk("rb_no_done", n_done - d0, 0);
        run_nominal();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
